// File: rtl/autosym_pkg.sv
// Shared types and helpers for the autosymmetric PLA evaluator.
package autosym_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROJ = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } state_t;

   // Widest vector the parity helper accepts; callers zero-extend into it.
   localparam int PAR_W = 64;

   function automatic logic parity(input logic [PAR_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/autosym_proj.sv
// GF(2) projection matrix: z[j] = parity(x & row_j), rows reset to identity.
module autosym_proj
   import autosym_pkg::*;
#(
   parameter int N_IN  = 8,
   parameter int N_RED = 8,
   localparam int AW   = (N_RED > 1) ? $clog2(N_RED) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [N_IN-1:0]  row,
   input  logic [N_IN-1:0]  x,
   output logic [N_RED-1:0] z
);

   logic [N_IN-1:0] rows_q [N_RED];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < N_RED; j++) begin
            rows_q[j] <= N_IN'(1) << j;
         end
      end else if (we) begin
         rows_q[addr] <= row;
      end
   end

   always_comb begin
      z = '0;
      for (int j = 0; j < N_RED; j++) begin
         z[j] = parity(PAR_W'(x & rows_q[j]));
      end
   end

endmodule

// File: rtl/autosym_pla_eval.sv
// Run-time programmable evaluator: project x onto reduced variables, then
// scan the cube table one entry per cycle and OR the matching cube outputs.
//
// state | meaning
// IDLE  | ready for input and configuration writes
// PROJ  | register projected z, clear accumulator, load scan counter
// SCAN  | test one cube per cycle, counter runs down to terminal count 0
// DONE  | result presented until out_ready
module autosym_pla_eval
   import autosym_pkg::*;
#(
   parameter int N_IN    = 8,
   parameter int N_RED   = 8,
   parameter int N_CUBES = 32,
   parameter int N_OUT   = 1,
   localparam int CAW    = (N_CUBES > 1) ? $clog2(N_CUBES) : 1,
   localparam int PAW    = (N_RED > 1) ? $clog2(N_RED) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cube_we,
   input  logic [CAW-1:0]   cube_addr,
   input  logic [N_RED-1:0] cube_care,
   input  logic [N_RED-1:0] cube_val,
   input  logic [N_OUT-1:0] cube_out,
   input  logic             proj_we,
   input  logic [PAW-1:0]   proj_addr,
   input  logic [N_IN-1:0]  proj_row,
   output logic             cfg_drop,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_OUT-1:0] out_y
);

   typedef struct packed {
      logic [N_RED-1:0] care;
      logic [N_RED-1:0] val;
      logic [N_OUT-1:0] outs;
   } cube_t;

   state_t           state_q, state_d;
   cube_t            cube_q [N_CUBES];
   cube_t            cube_cur;
   logic [N_IN-1:0]  x_q;
   logic [N_RED-1:0] z, z_q;
   logic [N_OUT-1:0] acc_q, acc_next, out_y_q;
   logic [CAW-1:0]   cnt_q;
   logic             cfg_ok, cube_hit, cfg_drop_q;

   assign cfg_ok = (state_q == IDLE);

   autosym_proj #(.N_IN(N_IN), .N_RED(N_RED)) u_proj (
      .clk  (clk),
      .rst  (rst),
      .we   (proj_we & cfg_ok),
      .addr (proj_addr),
      .row  (proj_row),
      .x    (x_q),
      .z    (z)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < N_CUBES; c++) begin
            cube_q[c] <= '0;
         end
      end else if (cube_we && cfg_ok) begin
         cube_q[cube_addr] <= '{care: cube_care, val: cube_val, outs: cube_out};
      end
   end

   // Cubes are visited from N_CUBES-1 down to 0; order is irrelevant to an OR.
   always_comb begin
      cube_cur = cube_q[cnt_q];
      cube_hit = (((z_q ^ cube_cur.val) & cube_cur.care) == '0);
      acc_next = acc_q | (cube_hit ? cube_cur.outs : '0);
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = PROJ;
         end
         PROJ: state_d = SCAN;
         SCAN: if (cnt_q == '0) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= '0;
         z_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_y_q    <= '0;
         cfg_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_drop_q <= (cube_we | proj_we) & ~cfg_ok;
         case (state_q)
            IDLE: if (in_valid) x_q <= in_x;
            PROJ: begin
               z_q   <= z;
               acc_q <= '0;
               cnt_q <= CAW'(N_CUBES - 1);
            end
            SCAN: begin
               acc_q <= acc_next;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) out_y_q <= acc_next;
            end
            default: ;
         endcase
      end
   end

   assign out_y    = out_y_q;
   assign cfg_drop = cfg_drop_q;

endmodule

// File: tb/tb_autosym_pla_eval.sv
// Self-checking bench for autosym_pla_eval: directed scenarios plus random
// configurations compared against a direct sum-of-products reference model.
module tb_autosym_pla_eval;

   localparam int N_IN    = 8;
   localparam int N_RED   = 8;
   localparam int N_CUBES = 4;
   localparam int N_OUT   = 1;

   logic       clk = 1'b0;
   logic       rst, cube_we, proj_we, in_valid, out_ready;
   logic [1:0] cube_addr;
   logic [2:0] proj_addr;
   logic [7:0] cube_care, cube_val, proj_row, in_x;
   logic [0:0] cube_out;
   logic       cfg_drop, in_ready, out_valid;
   logic [0:0] out_y;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] m_row  [N_RED];
   logic [7:0] m_care [N_CUBES];
   logic [7:0] m_val  [N_CUBES];
   logic       m_out  [N_CUBES];

   autosym_pla_eval #(.N_IN(N_IN), .N_RED(N_RED), .N_CUBES(N_CUBES), .N_OUT(N_OUT)) dut (
      .clk(clk), .rst(rst),
      .cube_we(cube_we), .cube_addr(cube_addr), .cube_care(cube_care),
      .cube_val(cube_val), .cube_out(cube_out),
      .proj_we(proj_we), .proj_addr(proj_addr), .proj_row(proj_row),
      .cfg_drop(cfg_drop),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int j = 0; j < N_RED; j++) m_row[j] = 8'(1) << j;
      for (int c = 0; c < N_CUBES; c++) begin
         m_care[c] = 8'h00; m_val[c] = 8'h00; m_out[c] = 1'b0;
      end
   endfunction

   function automatic logic model_eval(input logic [7:0] x);
      logic [7:0] z;
      logic       f;
      for (int j = 0; j < N_RED; j++) z[j] = ^(x & m_row[j]);
      f = 1'b0;
      for (int c = 0; c < N_CUBES; c++)
         if (m_out[c] && ((z ^ m_val[c]) & m_care[c]) == 8'h00) f = 1'b1;
      return f;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic wr_cube(input int a, input logic [7:0] care, input logic [7:0] val, input logic o);
      cube_we = 1'b1; cube_addr = 2'(a); cube_care = care; cube_val = val; cube_out = o;
      @(posedge clk); #1 cube_we = 1'b0;
      m_care[a] = care; m_val[a] = val; m_out[a] = o;
      chk("idle_wr_nodrop", cfg_drop, 0);
   endtask

   task automatic wr_proj(input int a, input logic [7:0] row);
      proj_we = 1'b1; proj_addr = 3'(a); proj_row = row;
      @(posedge clk); #1 proj_we = 1'b0;
      m_row[a] = row;
      chk("idle_wr_nodrop", cfg_drop, 0);
   endtask

   // mode 0: plain, 1: dropped cube write mid-scan, 2: reset mid-scan
   task automatic eval(input logic [7:0] x, input int hold, input int mode, output logic y);
      int lat, nv;
      lat = 0;
      y = 1'b0;
      in_valid = 1'b1; in_x = x;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (mode == 1 && k == 3) begin
            cube_we = 1'b1; cube_addr = 2'd1; cube_care = 8'h00; cube_val = 8'h00; cube_out = 1'b1;
         end
         if (mode == 1 && k == 4) begin
            cube_we = 1'b0;
            chk("drop_pulse", cfg_drop, 1);
         end
         if (mode == 1 && k == 5) chk("drop_clear", cfg_drop, 0);
         if (mode == 2 && k == 3) begin
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            chk("rst_ready", in_ready, 1);
            chk("rst_valid", out_valid, 0);
            nv = 0;
            repeat (8) begin
               @(negedge clk);
               if (out_valid) nv++;
            end
            chk("rst_no_result", nv, 0);
            model_reset();
            return;
         end
         if (out_valid) lat = k;
      end
      chk("latency", lat, N_CUBES + 2);
      y = out_y;
      for (int h = 0; h < hold; h++) begin
         if (h == 1) begin in_valid = 1'b1; in_x = ~x; end
         if (h == 2) in_valid = 1'b0;
         @(negedge clk);
         chk("hold_y", out_y, y);
         chk("hold_valid", out_valid, 1);
         chk("hold_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk("ret_ready", in_ready, 1);
      chk("ret_valid", out_valid, 0);
      if (hold > 1) begin
         @(posedge clk); #1;
         chk("no_accept_in_done", in_ready, 1);
      end
   endtask

   initial begin
      logic       y;
      logic [7:0] rx;
      int         hold, mode;

      rst = 1'b0; cube_we = 1'b0; proj_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      cube_addr = '0; proj_addr = '0; cube_care = '0; cube_val = '0; proj_row = '0;
      cube_out = '0; in_x = '0;

      // 1: reset state and empty table
      do_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_cfg_drop", cfg_drop, 0);
      eval(8'hFF, 0, 0, y); chk("t1_ff", y, 0);

      // 2: identity projection, single cube
      wr_cube(0, 8'h0F, 8'h05, 1'b1);
      eval(8'h35, 0, 0, y); chk("t2_35", y, 1);
      eval(8'h36, 0, 0, y); chk("t2_36", y, 0);
      eval(8'hF5, 0, 0, y); chk("t2_f5", y, 1);

      // 3: XOR invariance through projection row 0 = 0x03
      wr_proj(0, 8'h03);
      wr_cube(0, 8'h01, 8'h01, 1'b1);
      eval(8'h01, 0, 0, y); chk("t3_01", y, 1);
      eval(8'h02, 0, 0, y); chk("t3_02", y, 1);
      eval(8'h03, 0, 0, y); chk("t3_03", y, 0);
      eval(8'h00, 0, 0, y); chk("t3_00", y, 0);

      // 4: back-pressure in DONE
      eval(8'h01, 5, 0, y); chk("t4_y", y, 1);

      // 5: write during SCAN is dropped, then lands in IDLE
      eval(8'h03, 0, 1, y); chk("t5_dropped", y, 0);
      wr_cube(1, 8'h00, 8'h00, 1'b1);
      eval(8'h03, 0, 0, y); chk("t5_applied", y, 1);
      rx = 8'($urandom);
      eval(rx, 0, 0, y); chk("t5_any_x", y, 1);

      // 6: reset mid-scan aborts and clears the table
      eval(8'h03, 0, 2, y);
      eval(8'h35, 0, 0, y); chk("t6_cleared", y, 0);

      // random configurations against the reference model
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0)
            wr_proj($urandom_range(0, N_RED - 1), 8'($urandom));
         if ($urandom_range(0, 1) == 0)
            wr_cube($urandom_range(0, N_CUBES - 1), 8'($urandom & $urandom & $urandom),
                    8'($urandom), 1'($urandom));
         rx   = 8'($urandom);
         hold = $urandom_range(0, 2);
         mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
         eval(rx, hold, mode, y);
         chk("rand_y", y, model_eval(rx));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
